// File: rtl/lighting_actuator.sv
// lighting_actuator: accepts lamp-count and shade targets over a valid/ready
// handshake and slews the lamp bank and shade motor toward them, one unit
// per STEP_DIV clocks, pulsing done when both targets are reached.
module lighting_actuator #(
  parameter int STEP_DIV  = 4,
  parameter int SHADE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_lightnum,
  input  logic [3:0]  req_wshade,
  output logic [15:0] lamp_on,
  output logic [3:0]  cur_lightnum,
  output logic [3:0]  shade_pos,
  output logic        shade_up,
  output logic        shade_down,
  output logic        busy,
  output logic        done
);

  localparam int              TW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [3:0]      SHADE_LIM = 4'(SHADE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    cur_n_q, cur_n_d;
  logic [3:0]    shade_q, shade_d;
  logic [3:0]    tgt_n_q, tgt_n_d;
  logic [3:0]    tgt_s_q, tgt_s_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic [3:0]    req_s_clamped;

  assign req_s_clamped = (req_wshade > SHADE_LIM) ? SHADE_LIM : req_wshade;

  // Next-state logic: accept in IDLE, slew one unit per step cycle in STEP.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cur_n_d = cur_n_q;
    shade_d = shade_q;
    tgt_n_d = tgt_n_q;
    tgt_s_d = tgt_s_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tgt_n_d = req_lightnum;
          tgt_s_d = req_s_clamped;
          tick_d  = '0;
          if (req_lightnum == cur_n_q && req_s_clamped == shade_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (cur_n_q < tgt_n_q) begin
            cur_n_d = cur_n_q + 4'd1;
          end else if (cur_n_q > tgt_n_q) begin
            cur_n_d = cur_n_q - 4'd1;
          end
          if (shade_q < tgt_s_q) begin
            shade_d = shade_q + 4'd1;
            up_d    = 1'b1;
          end else if (shade_q > tgt_s_q) begin
            shade_d = shade_q - 4'd1;
            down_d  = 1'b1;
          end
          if (cur_n_d == tgt_n_q && shade_d == tgt_s_q) begin
            state_d = S_DONE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any move in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      cur_n_q <= '0;
      shade_q <= '0;
      tgt_n_q <= '0;
      tgt_s_q <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cur_n_q <= cur_n_d;
      shade_q <= shade_d;
      tgt_n_q <= tgt_n_d;
      tgt_s_q <= tgt_s_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  // Thermometer lamp drive straight from the registered count; bit 15 can
  // never be set because the count tops out at 15.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lamp
      assign lamp_on[gi] = ({1'b0, cur_n_q} > 5'(gi));
    end
  endgenerate

  assign cur_lightnum = cur_n_q;
  assign shade_pos    = shade_q;
  assign shade_up     = up_q;
  assign shade_down   = down_q;
  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q == S_STEP) || (state_q == S_DONE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_lighting_actuator.sv
// tb_lighting_actuator: directed plus randomized requests checked cycle by
// cycle against an arithmetic model of the slew (position after m steps is
// start + sign * min(m, distance)).
module tb_lighting_actuator;

  localparam int D  = 4;
  localparam int SM = 12;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_lightnum;
  logic [3:0]  req_wshade;
  logic [15:0] lamp_on;
  logic [3:0]  cur_lightnum;
  logic [3:0]  shade_pos;
  logic        shade_up;
  logic        shade_down;
  logic        busy;
  logic        done;

  lighting_actuator #(.STEP_DIV(D), .SHADE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_lightnum(req_lightnum), .req_wshade(req_wshade), .lamp_on(lamp_on),
    .cur_lightnum(cur_lightnum), .shade_pos(shade_pos), .shade_up(shade_up),
    .shade_down(shade_down), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cur_n = 0;
  int cur_s = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int isgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected lamp pattern: the lowest n bits set.
  function automatic logic [31:0] therm(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_n"}, 32'(cur_lightnum), 32'd0);
    check({tag, "_s"}, 32'(shade_pos), 32'd0);
    check({tag, "_lamp"}, 32'(lamp_on), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_up"}, 32'(shade_up), 32'd0);
    check({tag, "_down"}, 32'(shade_down), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request from a negedge and follow it to completion.
  // noisy: keep req_valid high with junk while the block is busy.
  // abort_at: if >= 0, pull reset at that cycle offset and check the abort.
  task automatic run_req(input int tn, input int ts, input bit noisy, input int abort_at);
    int tgt_s, dn, ds, k, m, en, es;
    bit step_edge, up_e, down_e;
    tgt_s = (ts > SM) ? SM : ts;
    dn    = tn - cur_n;
    ds    = tgt_s - cur_s;
    k     = (iabs(dn) > iabs(ds)) ? iabs(dn) : iabs(ds);
    req_valid    = 1'b1;
    req_lightnum = 4'(tn);
    req_wshade   = 4'(ts);
    @(posedge clk);
    for (int j = 0; j <= k * D + 1; j++) begin
      @(negedge clk);
      m         = imin(j / D, k);
      en        = cur_n + isgn(dn) * imin(m, iabs(dn));
      es        = cur_s + isgn(ds) * imin(m, iabs(ds));
      step_edge = (j > 0) && (j % D == 0) && (j <= k * D);
      up_e      = step_edge && (ds > 0) && (j / D <= iabs(ds));
      down_e    = step_edge && (ds < 0) && (j / D <= iabs(ds));
      check("n", 32'(cur_lightnum), 32'(en));
      check("s", 32'(shade_pos), 32'(es));
      check("lamp", 32'(lamp_on), therm(en));
      check("up", 32'(shade_up), 32'(up_e));
      check("down", 32'(shade_down), 32'(down_e));
      check("busy", 32'(busy), 32'(j <= k * D));
      check("done", 32'(done), 32'(j == k * D));
      check("ready", 32'(req_ready), 32'(j == k * D + 1));
      if (abort_at >= 0 && j == abort_at) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("abort");
        rst_n = 1'b1;
        cur_n = 0;
        cur_s = 0;
        $display("req n=%0d s=%0d aborted at cycle %0d", tn, ts, j);
        return;
      end
      if (noisy && j < k * D) begin
        req_valid    = 1'b1;
        req_lightnum = 4'($urandom_range(0, 15));
        req_wshade   = 4'($urandom_range(0, 15));
      end else begin
        req_valid = 1'b0;
      end
    end
    cur_n = tn;
    cur_s = tgt_s;
    $display("req n=%0d s=%0d -> steps=%0d noisy=%0d lamps=%0d shade=%0d", tn, ts, k, noisy,
             cur_lightnum, shade_pos);
  endtask

  initial begin
    int tn, ts;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_lightnum = 4'd0;
    req_wshade   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    run_req(3, 2, 1'b0, -1);           // basic ramp up
    run_req(0, 15, 1'b0, -1);          // lamps down, shade up, shade clamped
    run_req(0, 15, 1'b0, -1);          // no-op after clamp
    run_req(9, 3, 1'b1, -1);           // junk requests while busy
    run_req(8, 14, 1'b0, 2 * D + 1);   // reset mid-move
    run_req(5, 14, 1'b0, -1);          // clamp from zero
    run_req(5, 12, 1'b0, -1);          // no-op at the limit

    for (int i = 0; i < 30; i++) begin
      tn = int'($urandom_range(0, 15));
      ts = int'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        tn = cur_n;
        ts = cur_s;
      end
      run_req(tn, ts, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
